// File: rtl/dot_map.sv
// dot_map: per-tile record of small and big dots for a COL_NUM x ROW_NUM maze.
//
// Tiles are addressed by (col, row); the flat bit index is row*COL_NUM + col.
// An eat request clears both dot kinds at the addressed tile. The next cycle
// brings one pulse saying which kind was eaten, with the big dot taking
// priority. A counter tracks how many tiles still hold any dot. When it
// reaches zero the block enters CLEAR. Only reload or reset leaves CLEAR.
//
// Ports
//   clk              in   system clock
//   reset            in   asynchronous active-high reset (restores init maps)
//   reload           in   synchronous restart of the level (wins over eats)
//   eat_valid        in   eat request qualifier
//   eat_col/eat_row  in   tile being eaten
//   rd_col/rd_row    in   tile being rendered
//   rd_dot/rd_big    out  registered dot flags of the render tile (1-cycle latency)
//   eat_dot/eat_big  out  one-cycle pulse: a small / big dot was eaten
//   remaining        out  number of tiles still holding any dot
//   level_clear      out  one-cycle pulse when the last dot is eaten
//   cleared          out  high while in the CLEAR state
//   tilemap_dots     out  flat small-dot map (direct register view)
//   tilemap_big_dots out  flat big-dot map (direct register view)
module dot_map #(
    parameter int COL_NUM = 32,
    parameter int ROW_NUM = 24,
    parameter logic [COL_NUM*ROW_NUM-1:0] DOT_INIT = '0,
    parameter logic [COL_NUM*ROW_NUM-1:0] BIG_INIT = '0,
    localparam int N  = COL_NUM * ROW_NUM,
    localparam int CW = $clog2(COL_NUM),
    localparam int RW = $clog2(ROW_NUM),
    localparam int NW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reload,
    input  logic          eat_valid,
    input  logic [CW-1:0] eat_col,
    input  logic [RW-1:0] eat_row,
    input  logic [CW-1:0] rd_col,
    input  logic [RW-1:0] rd_row,
    output logic          rd_dot,
    output logic          rd_big,
    output logic          eat_dot,
    output logic          eat_big,
    output logic [NW-1:0] remaining,
    output logic          level_clear,
    output logic          cleared,
    output logic [N-1:0]  tilemap_dots,
    output logic [N-1:0]  tilemap_big_dots
);

    // Number of set bits, used at elaboration for the initial tile count.
    function automatic logic [NW-1:0] popcount(input logic [N-1:0] v);
        int c;
        c = 0;
        for (int k = 0; k < N; k++) begin
            if (v[k]) c++;
        end
        return NW'(c);
    endfunction

    // One-hot mask of the addressed tile; all-zero when the coordinate lies
    // outside the map. A mask avoids indexing with a non-power-of-two range.
    function automatic logic [N-1:0] tile_mask(input logic [CW-1:0] col,
                                               input logic [RW-1:0] row);
        logic [N-1:0] m;
        int           idx;
        m = '0;
        if (int'(col) < COL_NUM && int'(row) < ROW_NUM) begin
            idx = int'(row) * COL_NUM + int'(col);
            for (int k = 0; k < N; k++) begin
                m[k] = (k == idx);
            end
        end
        return m;
    endfunction

    localparam logic [NW-1:0] INIT_COUNT = popcount(DOT_INIT | BIG_INIT);

    localparam logic [0:0] S_PLAY  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    // An empty level starts already cleared, without a level_clear pulse.
    localparam logic [0:0] INIT_STATE = (INIT_COUNT == '0) ? S_CLEAR : S_PLAY;

    logic [N-1:0]  r_dots;
    logic [N-1:0]  r_bigs;
    logic [NW-1:0] r_remaining;
    logic [0:0]    r_state;
    logic          r_eat_dot;
    logic          r_eat_big;
    logic          r_level_clear;
    logic          r_rd_dot;
    logic          r_rd_big;

    logic [N-1:0]  w_eat_mask;
    logic [N-1:0]  w_rd_mask;
    logic          w_hit_dot;
    logic          w_hit_big;
    logic          w_eat_take;

    assign w_eat_mask = eat_valid ? tile_mask(eat_col, eat_row) : '0;
    assign w_rd_mask  = tile_mask(rd_col, rd_row);
    assign w_hit_dot  = |(r_dots & w_eat_mask);
    assign w_hit_big  = |(r_bigs & w_eat_mask);

    // Only an eat that actually removes something changes state; empty tiles,
    // out-of-range coordinates and eats while cleared are no-ops.
    assign w_eat_take = (r_state == S_PLAY) && (w_hit_dot || w_hit_big);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dots        <= DOT_INIT;
            r_bigs        <= BIG_INIT;
            r_remaining   <= INIT_COUNT;
            r_state       <= INIT_STATE;
            r_eat_dot     <= 1'b0;
            r_eat_big     <= 1'b0;
            r_level_clear <= 1'b0;
            r_rd_dot      <= 1'b0;
            r_rd_big      <= 1'b0;
        end else begin
            r_eat_dot     <= 1'b0;
            r_eat_big     <= 1'b0;
            r_level_clear <= 1'b0;

            // Render lookup sees the maps as they were before this edge.
            r_rd_dot <= |(r_dots & w_rd_mask);
            r_rd_big <= |(r_bigs & w_rd_mask);

            if (reload) begin
                // Reload wins over any eat presented in the same cycle.
                r_dots      <= DOT_INIT;
                r_bigs      <= BIG_INIT;
                r_remaining <= INIT_COUNT;
                r_state     <= INIT_STATE;
            end else if (w_eat_take) begin
                r_dots    <= r_dots & ~w_eat_mask;
                r_bigs    <= r_bigs & ~w_eat_mask;
                r_eat_big <= w_hit_big;
                r_eat_dot <= w_hit_dot && !w_hit_big;
                if (r_remaining != '0) begin
                    r_remaining <= r_remaining - NW'(1);
                end
                if (r_remaining == NW'(1)) begin
                    r_state       <= S_CLEAR;
                    r_level_clear <= 1'b1;
                end
            end
        end
    end

    assign rd_dot           = r_rd_dot;
    assign rd_big           = r_rd_big;
    assign eat_dot          = r_eat_dot;
    assign eat_big          = r_eat_big;
    assign remaining        = r_remaining;
    assign level_clear      = r_level_clear;
    assign cleared          = (r_state == S_CLEAR);
    assign tilemap_dots     = r_dots;
    assign tilemap_big_dots = r_bigs;

endmodule

// File: tb/tb_dot_map.sv
// Bench for dot_map: directed level walk-through followed by random traffic,
// checked against a tile-array model through an expected-response queue.
module tb_dot_map;

    localparam int C = 4;
    localparam int R = 2;
    localparam int N = C * R;
    localparam logic [7:0] DI = 8'h07;
    localparam logic [7:0] BI = 8'h84;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reload = 1'b0;
    logic       eat_valid = 1'b0;
    logic [1:0] eat_col = '0;
    logic       eat_row = 1'b0;
    logic [1:0] rd_col = '0;
    logic       rd_row = 1'b0;
    logic       rd_dot, rd_big, eat_dot, eat_big, level_clear, cleared;
    logic [3:0] remaining;
    logic [7:0] tm_d, tm_b;

    // Second instance with a 3-row map so a row index of 3 is out of range.
    logic [1:0]  rd2_col = 2'd3;
    logic [1:0]  rd2_row = 2'd3;
    logic        rd2_dot, rd2_big, eat2_dot, eat2_big, lc2, clr2;
    logic [3:0]  rem2;
    logic [11:0] tm2_d, tm2_b;

    always #5 clk = ~clk;

    dot_map #(.COL_NUM(C), .ROW_NUM(R), .DOT_INIT(DI), .BIG_INIT(BI)) dut (
        .clk(clk), .reset(reset), .reload(reload), .eat_valid(eat_valid),
        .eat_col(eat_col), .eat_row(eat_row), .rd_col(rd_col), .rd_row(rd_row),
        .rd_dot(rd_dot), .rd_big(rd_big), .eat_dot(eat_dot), .eat_big(eat_big),
        .remaining(remaining), .level_clear(level_clear), .cleared(cleared),
        .tilemap_dots(tm_d), .tilemap_big_dots(tm_b)
    );

    dot_map #(.COL_NUM(4), .ROW_NUM(3), .DOT_INIT(12'h007), .BIG_INIT(12'h084)) dut2 (
        .clk(clk), .reset(reset), .reload(1'b0), .eat_valid(1'b0),
        .eat_col(2'd0), .eat_row(2'd0), .rd_col(rd2_col), .rd_row(rd2_row),
        .rd_dot(rd2_dot), .rd_big(rd2_big), .eat_dot(eat2_dot), .eat_big(eat2_big),
        .remaining(rem2), .level_clear(lc2), .cleared(clr2),
        .tilemap_dots(tm2_d), .tilemap_big_dots(tm2_b)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] b;
        logic [3:0] rem;
        logic       clr;
        logic       ed;
        logic       eb;
        logic       lc;
        logic       rdd;
        logic       rdb;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: one flag pair per tile plus the cleared flag.
    bit m_dot[N];
    bit m_big[N];
    bit m_clear;

    function automatic int m_count();
        int c;
        c = 0;
        for (int i = 0; i < N; i++) if (m_dot[i] || m_big[i]) c++;
        return c;
    endfunction

    task automatic model_init();
        logic [7:0] vd, vb;
        vd = DI;
        vb = BI;
        for (int i = 0; i < N; i++) begin
            m_dot[i] = vd[i];
            m_big[i] = vb[i];
        end
        m_clear = (m_count() == 0);
    endtask

    task automatic fill_state(inout exp_t e);
        for (int i = 0; i < N; i++) begin
            e.d[i] = m_dot[i];
            e.b[i] = m_big[i];
        end
        e.rem = 4'(m_count());
        e.clr = m_clear;
    endtask

    task automatic push_reset();
        exp_t e;
        e = '0;
        model_init();
        fill_state(e);
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Drive one cycle of stimulus, predict the outputs after the next edge.
    task automatic step(input bit rl, input bit ev, input int c, input int r,
                        input int rc, input int rr);
        exp_t e;
        int   i;
        reload    = rl;
        eat_valid = ev;
        eat_col   = 2'(c);
        eat_row   = 1'(r);
        rd_col    = 2'(rc);
        rd_row    = 1'(rr);
        e = '0;
        e.rdd = m_dot[rr * C + rc];
        e.rdb = m_big[rr * C + rc];
        if (rl) begin
            model_init();
        end else if (ev && !m_clear && c < C && r < R) begin
            i = r * C + c;
            if (m_big[i]) e.eb = 1'b1;
            else if (m_dot[i]) e.ed = 1'b1;
            if (m_dot[i] || m_big[i]) begin
                m_dot[i] = 1'b0;
                m_big[i] = 1'b0;
                if (m_count() == 0) begin
                    m_clear = 1'b1;
                    e.lc    = 1'b1;
                end
            end
        end
        fill_state(e);
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    exp_t mon_e, mon_a;
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            mon_a = {tm_d, tm_b, remaining, cleared, eat_dot, eat_big, level_clear, rd_dot, rd_big};
            total++;
            if (mon_a !== mon_e) begin
                bad++;
                $display("FAIL cycle_outputs at %0t: got d=%h b=%h rem=%0d clr=%b ed=%b eb=%b lc=%b rd=%b%b expected d=%h b=%h rem=%0d clr=%b ed=%b eb=%b lc=%b rd=%b%b",
                         $time, mon_a.d, mon_a.b, mon_a.rem, mon_a.clr, mon_a.ed, mon_a.eb, mon_a.lc, mon_a.rdd, mon_a.rdb,
                         mon_e.d, mon_e.b, mon_e.rem, mon_e.clr, mon_e.ed, mon_e.eb, mon_e.lc, mon_e.rdd, mon_e.rdb);
            end
        end
    end

    initial begin
        int guard;
        reset = 1'b1;
        push_reset();
        @(posedge clk);
        #2;
        push_reset();
        @(posedge clk);
        #2;
        check("reset_tilemap_dots", tm_d, 32'h07);
        check("reset_tilemap_big", tm_b, 32'h84);
        reset = 1'b0;

        // Directed level: eat every dotted tile, then reload while cleared.
        step(0, 1, 0, 0, 3, 1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 2, 0, 2, 0);
        step(0, 1, 1, 0, 1, 0);
        step(0, 1, 3, 1, 3, 1);
        step(0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 2, 0);

        // Out-of-range render row, then an in-range render of a big dot.
        check("rd_row_out_of_range", {rd2_dot, rd2_big}, 32'h0);
        check("inst2_idle", {tm2_d, tm2_b, rem2, clr2, eat2_dot, eat2_big, lc2},
              {12'h007, 12'h084, 4'd4, 4'b0000});
        rd2_row = 2'd1;
        step(0, 0, 0, 0, 0, 0);
        check("rd_in_range_big", {rd2_dot, rd2_big}, 32'h1);

        // Reset arriving while an eat pulse is outstanding drops the pulse.
        step(0, 1, 2, 0, 0, 0);
        reset = 1'b1;
        #1;
        check("reset_drops_pulse", {eat_dot, eat_big, level_clear, rd_dot, rd_big}, 32'h0);
        check("reset_restores_maps", {tm_d, tm_b, remaining}, {8'h07, 8'h84, 4'd4});
        push_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        step(0, 1, 2, 0, 0, 0);

        // Random traffic with occasional reloads.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, C - 1)), int'($urandom_range(0, R - 1)),
                 int'($urandom_range(0, C - 1)), int'($urandom_range(0, R - 1)));
        end

        guard = 0;
        while (sb.size() != 0 && guard < 10) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check("scoreboard_drained", sb.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
